// File: rtl/mips_pkg.sv
// Shared MIPS32 definitions: opcodes, default word-address width and the
// fetch entry handed from fetch to decode.
package mips_pkg;

   localparam int ADDR_W_DEFAULT = 10;

   localparam logic [5:0] OP_ADD   = 6'b000000;
   localparam logic [5:0] OP_SUB   = 6'b000001;
   localparam logic [5:0] OP_AND   = 6'b000010;
   localparam logic [5:0] OP_OR    = 6'b000011;
   localparam logic [5:0] OP_SLT   = 6'b000100;
   localparam logic [5:0] OP_MUL   = 6'b000101;
   localparam logic [5:0] OP_LW    = 6'b001000;
   localparam logic [5:0] OP_SW    = 6'b001001;
   localparam logic [5:0] OP_ADDI  = 6'b001010;
   localparam logic [5:0] OP_SUBI  = 6'b001011;
   localparam logic [5:0] OP_SLTI  = 6'b001100;
   localparam logic [5:0] OP_BNEQZ = 6'b001101;
   localparam logic [5:0] OP_BEQZ  = 6'b001110;
   localparam logic [5:0] OP_HLT   = 6'b111111;

   typedef struct packed {
      logic [31:0]               ir;
      logic [ADDR_W_DEFAULT-1:0] npc;
   } fetch_entry_t;

   function automatic logic is_hlt(input logic [31:0] ir);
      return ir[31:26] == OP_HLT;
   endfunction

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry synchronous FIFO that absorbs instruction returns while decode
// is stalled. Clear empties it in one cycle (used on branch redirect).
module fetch_skid_fifo #(
   parameter int W = 42
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic         pop,
   input  logic         clear,
   input  logic [W-1:0] din,
   output logic [W-1:0] head,
   output logic [1:0]   count
);

   logic [W-1:0] mem [2];
   logic         rd_ptr;
   logic         wr_ptr;

   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage carries no reset; count alone says which slots are live.
   always_ff @(posedge clk) begin
      if (push && !clear) mem[wr_ptr] <= din;
   end

   assign head = mem[rd_ptr];

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(push && !pop && !clear && count == 2'd2));

endmodule

// File: rtl/mips_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues synchronous imem reads, parks
// returns in a 2-entry skid while decode stalls, and drives the IF/ID register.
module mips_fetch_stage
   import mips_pkg::*;
#(
   parameter int                ADDR_W   = ADDR_W_DEFAULT,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk1,
   input  logic              rst_n,
   output logic              imem_en,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [31:0]       imem_rdata,
   input  logic              id_stall,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic [31:0]       if_id_ir,
   output logic [ADDR_W-1:0] if_id_npc,
   output logic              if_id_valid,
   output logic              halted
);

   typedef struct packed {
      logic [31:0]       ir;
      logic [ADDR_W-1:0] npc;
   } entry_t;

   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] inflight_pc;
   logic              inflight;
   logic              halt_seen;
   logic              ret_valid;
   logic              ifid_load;
   logic              skid_pop;
   logic              skid_push;
   logic [1:0]        skid_count;
   entry_t            ret_entry;
   entry_t            skid_head;

   // Once HLT has returned, anything fetched behind it is wrong-path.
   assign ret_valid = inflight && !halt_seen;
   assign ret_entry = '{ir: imem_rdata, npc: inflight_pc + 1'b1};

   assign ifid_load = !id_stall || !if_id_valid;
   assign skid_pop  = !redirect_valid && ifid_load && (skid_count != 2'd0);
   assign skid_push = !redirect_valid && ret_valid && !(ifid_load && skid_count == 2'd0);

   // Counting the in-flight read against skid space is what keeps the skid from overflowing.
   assign imem_en   = rst_n && !halt_seen && !redirect_valid &&
                      ((3'(skid_count) + 3'(inflight)) < 3'd2);
   assign imem_addr = pc;
   assign halted    = halt_seen;

   fetch_skid_fifo #(
      .W($bits(entry_t))
   ) u_skid (
      .clk   (clk1),
      .rst_n (rst_n),
      .push  (skid_push),
      .pop   (skid_pop),
      .clear (redirect_valid),
      .din   (ret_entry),
      .head  (skid_head),
      .count (skid_count)
   );

   always_ff @(posedge clk1) begin
      if (!rst_n) begin
         pc          <= RESET_PC;
         inflight    <= 1'b0;
         inflight_pc <= '0;
         halt_seen   <= 1'b0;
         if_id_ir    <= '0;
         if_id_npc   <= '0;
         if_id_valid <= 1'b0;
      end else if (redirect_valid) begin
         pc          <= redirect_pc;
         inflight    <= 1'b0;
         halt_seen   <= 1'b0;
         if_id_valid <= 1'b0;
      end else begin
         inflight <= imem_en;
         if (imem_en) begin
            inflight_pc <= pc;
            pc          <= pc + 1'b1;
         end
         if (ret_valid && is_hlt(imem_rdata)) halt_seen <= 1'b1;
         if (ifid_load) begin
            if (skid_count != 2'd0) begin
               if_id_ir    <= skid_head.ir;
               if_id_npc   <= skid_head.npc;
               if_id_valid <= 1'b1;
            end else if (ret_valid) begin
               if_id_ir    <= ret_entry.ir;
               if_id_npc   <= ret_entry.npc;
               if_id_valid <= 1'b1;
            end else begin
               if_id_valid <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Directed bench for mips_fetch_stage: a synchronous instruction memory model
// and hand-derived cycle-by-cycle expectations for each scenario.
module tb_mips_fetch_stage;
   import mips_pkg::*;

   localparam int AW = 10;

   logic          clk1 = 1'b0;
   logic          rst_n;
   logic          imem_en;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_rdata = '0;
   logic          id_stall;
   logic          redirect_valid;
   logic [AW-1:0] redirect_pc;
   logic [31:0]   if_id_ir;
   logic [AW-1:0] if_id_npc;
   logic          if_id_valid;
   logic          halted;

   logic [31:0] mem [1024];
   logic [31:0] prog [5];
   int checks   = 0;
   int failures = 0;

   mips_fetch_stage #(.ADDR_W(AW), .RESET_PC('0)) dut (
      .clk1           (clk1),
      .rst_n          (rst_n),
      .imem_en        (imem_en),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .id_stall       (id_stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .if_id_ir       (if_id_ir),
      .if_id_npc      (if_id_npc),
      .if_id_valid    (if_id_valid),
      .halted         (halted)
   );

   always #5 clk1 = ~clk1;

   always @(posedge clk1) begin
      if (imem_en) imem_rdata <= mem[imem_addr];
   end

   function automatic logic [31:0] fill(input int a);
      return {OP_ADDI, 5'd0, 5'd9, 16'(a)};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk1);
      #1;
   endtask

   task automatic expect_ifid(input string tag, input int npc, input logic [31:0] ir);
      check({tag, " valid"}, 64'(if_id_valid), 64'd1);
      check({tag, " npc"}, 64'(if_id_npc), 64'(npc));
      check({tag, " ir"}, 64'(if_id_ir), 64'(ir));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = fill(i);
      prog[0] = {OP_ADD, 5'd1, 5'd2, 5'd3, 11'd0};
      prog[1] = {OP_SUB, 5'd4, 5'd3, 5'd5, 11'd0};
      prog[2] = {OP_SW, 5'd6, 5'd3, 16'd8};
      prog[3] = {OP_ADD, 5'd5, 5'd3, 5'd7, 11'd0};
      prog[4] = {OP_HLT, 26'd0};
      for (int i = 0; i < 5; i++) mem[i] = prog[i];

      rst_n = 1'b0; id_stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      cyc(); cyc();
      check("rst imem_en", 64'(imem_en), 64'd0);
      check("rst imem_addr", 64'(imem_addr), 64'd0);
      check("rst valid", 64'(if_id_valid), 64'd0);
      check("rst ir", 64'(if_id_ir), 64'd0);
      check("rst npc", 64'(if_id_npc), 64'd0);
      check("rst halted", 64'(halted), 64'd0);

      // Straight-line program, no stalls; cycle 0 is the first cycle out of reset.
      rst_n = 1'b1; #1;
      check("p c0 imem_en", 64'(imem_en), 64'd1);
      check("p c0 imem_addr", 64'(imem_addr), 64'd0);
      cyc();
      check("p c1 imem_addr", 64'(imem_addr), 64'd1);
      check("p c1 valid", 64'(if_id_valid), 64'd0);
      for (int k = 2; k <= 6; k++) begin
         cyc();
         expect_ifid("p stream", k - 1, prog[k-2]);
         check("p stream halted", 64'(halted), 64'(k == 6));
         check("p stream imem_en", 64'(imem_en), 64'(k != 6));
      end
      for (int k = 7; k <= 9; k++) begin
         cyc();
         check("p post-hlt valid", 64'(if_id_valid), 64'd0);
         check("p post-hlt imem_en", 64'(imem_en), 64'd0);
         check("p post-hlt halted", 64'(halted), 64'd1);
      end

      // Redirect out of the halted state.
      redirect_valid = 1'b1; redirect_pc = 10'd8; #1;
      check("hr R imem_en", 64'(imem_en), 64'd0);
      cyc(); redirect_valid = 1'b0; #1;
      check("hr R+1 halted", 64'(halted), 64'd0);
      check("hr R+1 imem_en", 64'(imem_en), 64'd1);
      check("hr R+1 imem_addr", 64'(imem_addr), 64'd8);
      check("hr R+1 valid", 64'(if_id_valid), 64'd0);
      cyc();
      check("hr R+2 imem_addr", 64'(imem_addr), 64'd9);
      cyc();
      expect_ifid("hr R+3", 9, fill(8));
      cyc();
      expect_ifid("hr R+4", 10, fill(9));

      // PC wrap at the top of the address space.
      redirect_valid = 1'b1; redirect_pc = 10'd1023;
      cyc(); redirect_valid = 1'b0; #1;
      check("wrap R+1 imem_addr", 64'(imem_addr), 64'd1023);
      cyc();
      check("wrap R+2 imem_addr", 64'(imem_addr), 64'd0);
      check("wrap R+2 valid", 64'(if_id_valid), 64'd0);
      cyc();
      expect_ifid("wrap R+3", 0, fill(1023));
      cyc();
      expect_ifid("wrap R+4", 1, prog[0]);

      // One-cycle reset in the middle of a stream.
      rst_n = 1'b0; #1;
      check("mrst imem_en low", 64'(imem_en), 64'd0);
      cyc(); rst_n = 1'b1; #1;
      check("mrst valid", 64'(if_id_valid), 64'd0);
      check("mrst ir", 64'(if_id_ir), 64'd0);
      check("mrst npc", 64'(if_id_npc), 64'd0);
      check("mrst halted", 64'(halted), 64'd0);
      check("mrst imem_en", 64'(imem_en), 64'd1);
      check("mrst imem_addr", 64'(imem_addr), 64'd0);
      cyc();
      check("mrst c1 valid", 64'(if_id_valid), 64'd0);
      cyc();
      expect_ifid("mrst c2", 1, prog[0]);
      cyc();
      expect_ifid("mrst c3", 2, prog[1]);

      // Three-cycle stall while SUB sits in IF/ID (cycles 3..5).
      id_stall = 1'b1; #1;
      check("stall c3 imem_en", 64'(imem_en), 64'd1);
      cyc();
      expect_ifid("stall c4", 2, prog[1]);
      check("stall c4 imem_en", 64'(imem_en), 64'd0);
      cyc();
      expect_ifid("stall c5", 2, prog[1]);
      check("stall c5 imem_en", 64'(imem_en), 64'd0);
      check("stall c5 skid_count", 64'(dut.skid_count), 64'd2);
      cyc(); id_stall = 1'b0; #1;
      expect_ifid("stall c6", 2, prog[1]);
      check("stall c6 imem_en", 64'(imem_en), 64'd0);
      cyc();
      expect_ifid("stall c7", 3, prog[2]);
      check("stall c7 imem_addr", 64'(imem_addr), 64'd4);
      cyc();
      expect_ifid("stall c8", 4, prog[3]);
      cyc();
      expect_ifid("stall c9", 5, prog[4]);
      check("stall c9 halted", 64'(halted), 64'd1);

      // Redirect while IF/ID + skid hold entries and a read is in flight.
      rst_n = 1'b0;
      cyc(); rst_n = 1'b1; #1;
      cyc(); cyc(); cyc();
      id_stall = 1'b1;
      cyc();
      check("flush R skid_count", 64'(dut.skid_count), 64'd1);
      id_stall = 1'b0; redirect_valid = 1'b1; redirect_pc = 10'd20; #1;
      check("flush R imem_en", 64'(imem_en), 64'd0);
      cyc(); redirect_valid = 1'b0; #1;
      check("flush R+1 valid", 64'(if_id_valid), 64'd0);
      check("flush R+1 imem_addr", 64'(imem_addr), 64'd20);
      check("flush R+1 skid_count", 64'(dut.skid_count), 64'd0);
      cyc();
      check("flush R+2 valid", 64'(if_id_valid), 64'd0);
      check("flush R+2 imem_addr", 64'(imem_addr), 64'd21);
      cyc();
      expect_ifid("flush R+3", 21, fill(20));

      // Redirect and stall in the same cycle: the flush wins.
      id_stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 10'd40; #1;
      check("rs R imem_en", 64'(imem_en), 64'd0);
      cyc(); id_stall = 1'b0; redirect_valid = 1'b0; #1;
      check("rs R+1 valid", 64'(if_id_valid), 64'd0);
      check("rs R+1 imem_addr", 64'(imem_addr), 64'd40);
      cyc(); cyc();
      expect_ifid("rs R+3", 41, fill(40));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mips_fetch_stage.md
# mips_fetch_stage

Instruction-fetch stage of the pipelined MIPS32 core. It sits directly upstream of decode and feeds the IF/ID register that decode, hazard detection and forwarding consume. It owns the PC and issues word reads to a synchronous instruction memory. It absorbs load-use stalls with a 2-entry skid buffer, squashes wrong-path fetches on a taken-branch redirect, and stops fetching once HLT has been fetched.

## Interface
Parameters:
- ADDR_W, 10: word-address width (1024-word memory).
- RESET_PC, 0: PC value after reset.

Ports:
- clk1  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- imem_en  out  1  read request this cycle (combinational from state).
- imem_addr  out  ADDR_W  word address of the request; equals pc.
- imem_rdata  in  32  read data, valid exactly one cycle after imem_en.
- id_stall  in  1  decode cannot accept; hold IF/ID.
- redirect_valid  in  1  taken branch resolved in EX.
- redirect_pc  in  ADDR_W  branch target (word address).
- if_id_ir  out  32  instruction in IF/ID.
- if_id_npc  out  ADDR_W  fetch address + 1.
- if_id_valid  out  1  IF/ID holds a live instruction.
- halted  out  1  HLT fetched; no further requests.

## Operation
- State: pc, inflight flag + inflight_pc, skid FIFO (ir, npc; depth 2, count 0..2), IF/ID register, halt_seen.
- Issue: imem_en = rst_n & !halt_seen & !redirect_valid & (skid_count + inflight < 2). On issue: inflight<=1, inflight_pc<=pc, pc<=pc+1, with wrap modulo 2^ADDR_W.
- Return: when inflight is set, imem_rdata belongs to inflight_pc. Entry = {rdata, inflight_pc+1}.
- IF/ID load is enabled when !id_stall or !if_id_valid. Source priority: skid head (pop), then the returning entry, else if_id_valid<=0.
- A returning entry not consumed by IF/ID is pushed to the skid. The issue rule guarantees the skid never overflows. A push to a full skid is a bug; assert on it in simulation.
- HLT: a returning word with opcode [31:26]==6'b111111 sets halt_seen and is itself delivered normally. Any fetch already issued behind it is dropped on return.
- Redirect (highest priority): skid cleared, in-flight return discarded, if_id_valid<=0, pc<=redirect_pc, halt_seen<=0. No issue in the redirect cycle.
- Redirect overrides id_stall in the same cycle.
- halted = halt_seen.

## Timing
- Reset values: pc=RESET_PC, if_id_ir=0, if_id_npc=0, if_id_valid=0, halted=0, imem_en=0 while rst_n low, skid empty, inflight=0.
- Assertion of rst_n mid-operation behaves like a redirect to RESET_PC; the data return in the next cycle is ignored.
- Latency: an issue in cycle N produces if_id_valid in cycle N+2 when unstalled. Throughput is 1 instruction/cycle.
- Redirect in cycle R: first target issue in R+1, target in IF/ID at R+3 (3-cycle bubble).
- id_stall for k cycles: IF/ID frozen, no instruction lost or duplicated, and at most 2 entries buffered. After release, back-to-back delivery resumes with no bubble.
- Simultaneous id_stall and return with the skid non-empty: return is pushed and head stays.

## Structure
- Shared package mips_pkg: opcode localparams (ADD..BEQZ, HLT=6'b111111), ADDR_W default, and a fetch entry struct {ir[31:0], npc[ADDR_W-1:0]}.
- Sub-module fetch_skid_fifo: 2-entry synchronous FIFO with push, pop, clear, count, head and synchronous active-low reset. All other logic stays in mips_fetch_stage.

## Test plan
- Reset, then a program MEM[0..4] = ADD, SUB, SW, ADD, HLT with no stalls. Required: IF/ID shows npc 1,2,3,4,5 on consecutive cycles starting at cycle 2, halted=1 the cycle after HLT returns, imem_en stays 0 afterwards, and the word at MEM[5] never appears in IF/ID.
- Hold id_stall for 3 cycles while SUB (npc=2) is in IF/ID. Required: IF/ID holds SUB, skid count reaches 2, and imem_en drops. After release, npc 3,4,5 follow on consecutive cycles.
- redirect_valid with redirect_pc=20 while 2 entries are buffered and 1 is in flight. Required: next cycle if_id_valid=0 and imem_addr=20, the returning data is dropped, and npc=21 appears 3 cycles after the redirect.
- redirect_valid and id_stall in the same cycle. Required: flush wins, if_id_valid=0, pc=redirect_pc.
- After HLT (halted=1), redirect to 8. Required: halted clears and fetch resumes at 8.
- pc=1023 with ADDR_W=10. Required: next issue at address 0, and IF/ID npc=0 for the word at 1023.
- rst_n low for 1 cycle mid-stream. Required: all outputs take their reset values, and the first post-reset issue uses imem_addr=0.
